// File: rtl/ysyx_23060171_mem_arbiter.sv
// Two-master memory arbiter: IFU and LSU share a single memory port.
// The LSU has fixed priority. One transaction is outstanding at a time,
// and a transaction still outstanding after TIMEOUT cycles is aborted.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transaction; accepts a request (LSU first)
// REQ    | mem_req_valid asserted, waiting for mem_req_ready
// WAIT   | request taken by memory, waiting for mem_resp_valid
module ysyx_23060171_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q;
    state_t      state_d;
    logic        owner_lsu_q;
    logic [7:0]  cnt_q;
    logic        take_lsu;
    logic        take_ifu;
    logic        resp_fire;
    logic        resp_err;
    logic        timed_out;

    assign timed_out = (cnt_q == TIMEOUT_CNT);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshakes and response strobe; reset gates every output.
    always_comb begin
        state_d       = state_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        take_lsu      = 1'b0;
        take_ifu      = 1'b0;
        resp_fire     = 1'b0;
        resp_err      = 1'b0;
        case (state_q)
            S_IDLE: begin
                lsu_req_ready = !reset;
                ifu_req_ready = !reset && !lsu_req_valid;
                if (lsu_req_valid) begin
                    take_lsu = 1'b1;
                    state_d  = S_REQ;
                end else if (ifu_req_valid) begin
                    take_ifu = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = !reset;
                // A response cannot arrive before the request is taken, so
                // expiry here is always an abort.
                if (timed_out) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = S_IDLE;
                end else if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real response beats a simultaneous expiry.
                if (mem_resp_valid) begin
                    resp_fire = 1'b1;
                    state_d   = S_IDLE;
                end else if (timed_out) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) begin
            resp_fire = 1'b0;
            resp_err  = 1'b0;
        end
    end

    // Owner, request latch and timeout counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_lsu_q <= 1'b0;
            cnt_q       <= 8'd0;
            mem_addr    <= '0;
            mem_wen     <= 1'b0;
            mem_wdata   <= '0;
            mem_wmask   <= 8'd0;
        end else if (take_lsu) begin
            owner_lsu_q <= 1'b1;
            cnt_q       <= 8'd0;
            mem_addr    <= lsu_addr;
            mem_wen     <= lsu_wen;
            mem_wdata   <= lsu_wdata;
            mem_wmask   <= lsu_wmask;
        end else if (take_ifu) begin
            owner_lsu_q <= 1'b0;
            cnt_q       <= 8'd0;
            mem_addr    <= ifu_addr;
            mem_wen     <= 1'b0;
            mem_wdata   <= '0;
            mem_wmask   <= 8'd0;
        end else if (state_q != S_IDLE) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Route the response to the owner only; timeouts carry zero data.
    always_comb begin
        ifu_resp_valid = resp_fire && !owner_lsu_q;
        ifu_resp_err   = resp_err && !owner_lsu_q;
        ifu_rdata      = (resp_fire && !resp_err && !owner_lsu_q) ? mem_rdata : '0;
        lsu_resp_valid = resp_fire && owner_lsu_q;
        lsu_resp_err   = resp_err && owner_lsu_q;
        lsu_rdata      = (resp_fire && !resp_err && owner_lsu_q) ? mem_rdata : '0;
    end

endmodule
